// File: rtl/sd_int_reg_bank_pkg.sv
// Shared definitions for the SD host interrupt register bank.
package sd_int_reg_bank_pkg;

  localparam int unsigned INT_ADDR_W = 2;

  typedef enum logic [INT_ADDR_W-1:0] {
    INT_ADDR_STATUS = 2'd0,
    INT_ADDR_STEN   = 2'd1,
    INT_ADDR_SGEN   = 2'd2,
    INT_ADDR_FORCE  = 2'd3
  } int_addr_e;

  // Normal interrupt event bit positions
  localparam int unsigned NI_CMD_COMPLETE  = 0;
  localparam int unsigned NI_XFER_COMPLETE = 1;
  localparam int unsigned NI_BLK_GAP       = 2;
  localparam int unsigned NI_DMA_INT       = 3;
  localparam int unsigned NI_BUF_WR_RDY    = 4;
  localparam int unsigned NI_BUF_RD_RDY    = 5;

  // Error interrupt event bit positions
  localparam int unsigned EI_CMD_TIMEOUT   = 0;
  localparam int unsigned EI_CMD_CRC       = 1;
  localparam int unsigned EI_CMD_END_BIT   = 2;
  localparam int unsigned EI_CMD_INDEX     = 3;
  localparam int unsigned EI_DAT_TIMEOUT   = 4;
  localparam int unsigned EI_DAT_CRC       = 5;
  localparam int unsigned EI_DAT_END_BIT   = 6;
  localparam int unsigned EI_ADMA          = 9;

endpackage

// File: rtl/sd_int_bit_cell.sv
// One sticky interrupt status bit: optional edge detect, set-over-clear priority.
module sd_int_bit_cell #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic evt,
  input  logic en,
  input  logic force_set,
  input  logic clr,
  output logic sts,
  output logic sts_nxt_c
);

  logic hit;

  generate
    if (EDGE) begin : g_edge
      logic evt_q;

      // Delay the raw event by one cycle for rising-edge detection
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) evt_q <= 1'b0;
        else        evt_q <= evt;
      end

      assign hit = evt & ~evt_q;
    end else begin : g_level
      assign hit = evt;
    end
  endgenerate

  // Next status: an enabled set wins over a simultaneous W1C
  always_comb begin
    sts_nxt_c = sts;
    if ((hit | force_set) & en) sts_nxt_c = 1'b1;
    else if (clr)               sts_nxt_c = 1'b0;
  end

  // Sticky status flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sts <= 1'b0;
    else        sts <= sts_nxt_c;
  end

endmodule

// File: rtl/sd_int_reg_bank.sv
// Interrupt status / status-enable / signal-enable / force register bank with one irq line.
module sd_int_reg_bank
  import sd_int_reg_bank_pkg::*;
#(
  parameter int unsigned      EVT_W     = 16,
  parameter logic [EVT_W-1:0] EDGE_MASK = '1,
  parameter logic [EVT_W-1:0] STS_RST   = '0,
  parameter logic [EVT_W-1:0] SIG_RST   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [EVT_W-1:0]      evt_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [INT_ADDR_W-1:0] addr,
  input  logic [EVT_W-1:0]      wr_data,
  output logic [EVT_W-1:0]      rd_data,
  output logic                  ack,
  output logic [EVT_W-1:0]      status,
  output logic                  irq
);

  logic             acc_c;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic [EVT_W-1:0] force_c;
  logic [EVT_W-1:0] clr_c;
  logic [EVT_W-1:0] sten;
  logic [EVT_W-1:0] sgen;
  logic [EVT_W-1:0] sten_nxt_c;
  logic [EVT_W-1:0] sgen_nxt_c;
  logic [EVT_W-1:0] status_nxt_c;
  logic [EVT_W-1:0] rd_mux_c;

  // Bus decode; requests during the ack cycle are dropped
  always_comb begin
    acc_c      = (wr_en | rd_en) & ~ack;
    wr_acc_c   = acc_c & wr_en;
    rd_acc_c   = acc_c & rd_en;
    force_c    = '0;
    clr_c      = '0;
    sten_nxt_c = sten;
    sgen_nxt_c = sgen;
    if (wr_acc_c) begin
      case (addr)
        INT_ADDR_STATUS: clr_c      = wr_data;
        INT_ADDR_STEN:   sten_nxt_c = wr_data;
        INT_ADDR_SGEN:   sgen_nxt_c = wr_data;
        default:         force_c    = wr_data;
      endcase
    end
  end

  // Read mux returns pre-write register contents
  always_comb begin
    rd_mux_c = '0;
    case (addr)
      INT_ADDR_STATUS: rd_mux_c = status;
      INT_ADDR_STEN:   rd_mux_c = sten;
      INT_ADDR_SGEN:   rd_mux_c = sgen;
      default:         rd_mux_c = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < EVT_W; gi++) begin : g_bit
      sd_int_bit_cell #(
        .EDGE (EDGE_MASK[gi])
      ) u_cell (
        .clk       (clk),
        .reset     (reset),
        .evt       (evt_in[gi]),
        .en        (sten[gi]),
        .force_set (force_c[gi]),
        .clr       (clr_c[gi]),
        .sts       (status[gi]),
        .sts_nxt_c (status_nxt_c[gi])
      );
    end
  endgenerate

  // Enable registers, bus response and interrupt line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sten    <= STS_RST;
      sgen    <= SIG_RST;
      ack     <= 1'b0;
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      sten <= sten_nxt_c;
      sgen <= sgen_nxt_c;
      ack  <= acc_c;
      if (rd_acc_c) rd_data <= rd_mux_c;
      irq  <= |(status_nxt_c & sgen_nxt_c);
    end
  end

endmodule

// File: tb/tb_sd_int_reg_bank.sv
// Randomised scoreboard bench for sd_int_reg_bank (16 events, bits 12..15 level-captured).
module tb_sd_int_reg_bank;

  localparam int unsigned W      = 16;
  localparam logic [W-1:0] EMASK = 16'h0FFF;
  localparam logic [W-1:0] STSR  = 16'h00A5;
  localparam logic [W-1:0] SIGR  = 16'h0003;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] evt_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [1:0]   addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic         ack;
  logic [W-1:0] status;
  logic         irq;

  sd_int_reg_bank #(
    .EVT_W     (W),
    .EDGE_MASK (EMASK),
    .STS_RST   (STSR),
    .SIG_RST   (SIGR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .evt_in  (evt_in),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .ack     (ack),
    .status  (status),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] st; logic irq; logic ack; } cyc_t;
  typedef struct { logic is_rd; logic [W-1:0] data; } acc_t;

  cyc_t cycq[$];
  acc_t accq[$];

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  // Reference model state
  logic [W-1:0] m_status, m_sten, m_sgen, m_prev;
  logic         m_ack;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus/event cycle: drive inputs, advance the model, queue expectations
  task automatic step(input logic w, input logic r, input logic [1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] e);
    logic         accepted;
    logic [W-1:0] rising, hits, setv, clrv, oldv;
    acc_t         ar;
    cyc_t         cr;
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wr_data = d; evt_in = e;
    accepted = (w | r) & ~m_ack;
    rising   = e & ~m_prev;
    hits     = (rising & EMASK) | (e & ~EMASK);
    case (a)
      2'd0:    oldv = m_status;
      2'd1:    oldv = m_sten;
      2'd2:    oldv = m_sgen;
      default: oldv = '0;
    endcase
    setv = hits;
    clrv = '0;
    if (accepted && w && a == 2'd3) setv = setv | d;
    if (accepted && w && a == 2'd0) clrv = d;
    setv     = setv & m_sten;
    m_status = setv | (m_status & ~clrv);
    if (accepted && w && a == 2'd1) m_sten = d;
    if (accepted && w && a == 2'd2) m_sgen = d;
    m_prev = e;
    m_ack  = accepted;
    if (accepted) begin
      ar.is_rd = r;
      ar.data  = oldv;
      accq.push_back(ar);
    end
    cr.st  = m_status;
    cr.irq = (m_status & m_sgen) != '0;
    cr.ack = accepted;
    cycq.push_back(cr);
    mon_on = 1'b1;
  endtask

  task automatic idle(input logic [W-1:0] e);
    step(1'b0, 1'b0, 2'd0, '0, e);
  endtask

  // Monitor: compare every cycle, pop bus expectations whenever ack is presented
  always @(posedge clk) begin
    #1;
    if (mon_on && reset) begin
      if (cycq.size() == 0) begin
        errors++; checks++;
        $display("FAIL cycq_empty: DUT cycle with no expectation at %0t", $time);
      end else begin
        cyc_t c;
        c = cycq.pop_front();
        chk("status", status, c.st);
        chk("irq", W'(irq), W'(c.irq));
        chk("ack", W'(ack), W'(c.ack));
      end
      if (ack) begin
        if (accq.size() == 0) begin
          errors++; checks++;
          $display("FAIL accq_empty: unexpected ack at %0t", $time);
        end else begin
          acc_t a;
          a = accq.pop_front();
          if (a.is_rd) chk("rd_data", rd_data, a.data);
        end
      end
    end
  end

  logic [W-1:0] ev;

  initial begin
    m_status = '0; m_sten = STSR; m_sgen = SIGR; m_prev = '0; m_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_status", status, '0);
    chk("rst_irq", W'(irq), '0);
    chk("rst_ack", W'(ack), '0);
    chk("rst_rd_data", rd_data, '0);
    reset = 1'b1;

    // Reset values read back
    step(0, 1, 2'd0, '0, '0); idle('0);
    step(0, 1, 2'd1, '0, '0); idle('0);
    step(0, 1, 2'd2, '0, '0); idle('0);

    // Single pulse raises status and irq, W1C clears
    step(1, 0, 2'd1, 16'h0003, '0); idle('0);
    step(1, 0, 2'd2, 16'h0001, '0); idle('0);
    idle(16'h0001); idle('0); idle('0);
    step(1, 0, 2'd0, 16'h0001, '0); idle('0);

    // Held edge event sets once; W1C sticks while source stays high; disabled bit 2
    step(1, 0, 2'd1, 16'h0003, '0); idle('0);
    for (int i = 0; i < 5; i++) idle(16'h0002);
    step(1, 0, 2'd0, 16'h0002, 16'h0002); idle(16'h0002); idle(16'h0002);
    idle(16'h0004); idle(16'h0004); idle('0);

    // Rising event and W1C in the same cycle: set wins
    step(1, 0, 2'd0, 16'h0001, 16'h0001); idle('0); idle('0);

    // Force, read of FORCE address, write+read same address
    step(1, 0, 2'd1, 16'hFFFF, '0); idle('0);
    step(1, 0, 2'd2, 16'h8000, '0); idle('0);
    step(1, 0, 2'd0, 16'hFFFF, '0); idle('0);
    step(1, 0, 2'd3, 16'h8000, '0); idle('0);
    step(0, 1, 2'd3, '0, '0); idle('0);
    step(1, 1, 2'd1, 16'h1234, '0); idle('0);
    step(0, 1, 2'd1, '0, '0); idle('0);

    // Level bit held high re-sets after W1C
    step(1, 0, 2'd2, 16'hF000, '0); idle('0);
    idle(16'h1000); idle(16'h1000);
    step(1, 0, 2'd0, 16'hFFFF, 16'h1000); idle(16'h1000); idle('0);
    step(1, 0, 2'd0, 16'hFFFF, '0); idle('0);

    // Randomised traffic, including back-to-back requests during ack
    ev = '0;
    for (int i = 0; i < 3000; i++) begin
      logic w, r;
      ev = ev ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      w  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) == 0);
      step(w, r, 2'($urandom_range(0, 3)), 16'($urandom), ev);
    end
    idle('0); idle('0);

    // Async reset while ack and status are set
    step(1, 0, 2'd1, 16'hFFFF, '0); idle('0);
    step(1, 0, 2'd2, 16'hFFFF, '0); idle('0);
    step(1, 0, 2'd3, 16'hFFFF, '0); idle('0);
    step(0, 1, 2'd0, '0, '0);
    @(posedge clk); #2;
    chk("pre_rst_ack", W'(ack), 16'h0001);
    chk("pre_rst_status", status, 16'hFFFF);
    mon_on = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_rst_ack", W'(ack), '0);
    chk("async_rst_irq", W'(irq), '0);
    chk("async_rst_status", status, '0);
    chk("cycq_drained", 16'(cycq.size()), '0);
    chk("accq_drained", 16'(accq.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
